// File: rtl/judge_pkg.sv
// Shared types for the answer judge: FSM states, verdict codes and
// a helper for the winner-index width.
package judge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE
  } state_t;

  localparam logic [1:0] RES_PEND = 2'b00;
  localparam logic [1:0] RES_OK   = 2'b01;
  localparam logic [1:0] RES_NG   = 2'b11;
  localparam logic [1:0] RES_TO   = 2'b10;

  function automatic int win_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/answer_judge_if.sv
// Question/answer bundle between a quiz host (master) and the judge (slave).
// Host drives Q_VALID/QUESTION/ANSWER/SUBMIT; judge returns RESULT/WINNER/WIN_VALID/BUSY.
interface answer_judge_if #(
  parameter int PLAYERS = 2,
  parameter int DIGITS  = 3,
  parameter int DIGIT_W = 4
);
  import judge_pkg::*;

  localparam int KW = DIGITS * DIGIT_W;
  localparam int WW = win_w(PLAYERS);

  logic                   Q_VALID;
  logic [2*KW-1:0]        QUESTION;
  logic [PLAYERS*KW-1:0]  ANSWER;
  logic [PLAYERS-1:0]     SUBMIT;
  logic [2*PLAYERS-1:0]   RESULT;
  logic [WW-1:0]          WINNER;
  logic                   WIN_VALID;
  logic                   BUSY;

  modport master (
    output Q_VALID, QUESTION, ANSWER, SUBMIT,
    input  RESULT, WINNER, WIN_VALID, BUSY
  );

  modport slave (
    input  Q_VALID, QUESTION, ANSWER, SUBMIT,
    output RESULT, WINNER, WIN_VALID, BUSY
  );

endinterface

// File: rtl/answer_judge_cmp.sv
// One player's answer-vs-key equality compare.
// Ports: a (answer), b (key), eq (1 when all digits match).
module answer_cmp #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/answer_judge.sv
// Quiz round judge: latches a key, grades registered player answers,
// picks the lowest-index winner, tracks tries and a round timeout.
// Ports: CLK, RST_N (sync, active-low), bus (answer_judge_if.slave).
module answer_judge
  import judge_pkg::*;
#(
  parameter int PLAYERS     = 2,
  parameter int DIGITS      = 3,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic         CLK,
  input  logic         RST_N,
  answer_judge_if.slave bus
);

  localparam int KW = DIGITS * DIGIT_W;
  localparam int WW = win_w(PLAYERS);
  localparam int CW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t                state;
  logic [KW-1:0]         key;
  logic [TW-1:0]         timer;
  logic [CW-1:0]         tries   [PLAYERS];
  logic [CW-1:0]         tries_n [PLAYERS];
  logic [PLAYERS-1:0]    sub_q;
  logic [PLAYERS*KW-1:0] ans_q;

  logic [PLAYERS-1:0]    match;
  logic [PLAYERS-1:0]    vld;
  logic [PLAYERS-1:0]    hit;
  logic                  win_any;
  logic [WW-1:0]         win_idx;
  logic                  timeout;
  logic                  all_out;
  logic                  leave;
  logic                  load;

  logic [2*PLAYERS-1:0]  result;
  logic [WW-1:0]         winner;
  logic                  win_valid;
  logic                  busy;

  logic [KW-1:0]         q_key;
  logic                  unused_q_hi;

  assign q_key       = bus.QUESTION[KW-1:0];
  assign unused_q_hi = ^bus.QUESTION[2*KW-1:KW];

  for (genvar g = 0; g < PLAYERS; g++) begin : g_cmp
    answer_cmp #(
      .W(KW)
    ) u_cmp (
      .a (ans_q[g*KW +: KW]),
      .b (key),
      .eq(match[g])
    );
  end

  assign load    = bus.Q_VALID && (q_key != '0)
                && (state != ARMED);
  assign timeout = (timer == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    vld     = '0;
    win_idx = '0;
    all_out = 1'b1;
    for (int p = 0; p < PLAYERS; p++) begin
      vld[p]     = sub_q[p] && (tries[p] != '0);
      tries_n[p] = tries[p];
      if (vld[p] && !match[p])
        tries_n[p] = tries[p] - CW'(1);
      if (tries_n[p] != '0)
        all_out = 1'b0;
    end
    hit     = vld & match;
    win_any = |hit;
    // Descending scan so the lowest set index is the last write.
    for (int p = PLAYERS - 1; p >= 0; p--)
      if (hit[p])
        win_idx = WW'(p);
    leave = (state == ARMED)
         && (win_any || timeout || all_out);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      key       <= '0;
      timer     <= '0;
      sub_q     <= '0;
      ans_q     <= '0;
      result    <= '0;
      winner    <= '0;
      win_valid <= 1'b0;
      busy      <= 1'b0;
      for (int p = 0; p < PLAYERS; p++)
        tries[p] <= '0;
    end else begin
      // Only capture submissions that a still-armed round can grade.
      sub_q <= (state == ARMED && !leave)
             ? bus.SUBMIT : '0;
      ans_q <= bus.ANSWER;
      unique case (state)
        IDLE, DONE: begin
          if (load) begin
            key       <= q_key;
            result    <= '0;
            win_valid <= 1'b0;
            timer     <= '0;
            busy      <= 1'b1;
            state     <= ARMED;
            for (int p = 0; p < PLAYERS; p++)
              tries[p] <= CW'(MAX_TRIES);
          end
        end
        ARMED: begin
          timer <= timer + TW'(1);
          if (win_any) begin
            result[2*win_idx +: 2] <= RES_OK;
            winner    <= win_idx;
            win_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            for (int p = 0; p < PLAYERS; p++) begin
              tries[p] <= tries_n[p];
              if (vld[p] && !match[p])
                result[2*p +: 2] <= RES_NG;
            end
            if (timeout) begin
              // No OK code can exist while armed.
              result <= {PLAYERS{RES_TO}};
              busy   <= 1'b0;
              state  <= DONE;
            end else if (all_out) begin
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RESULT    = result;
  assign bus.WINNER    = winner;
  assign bus.WIN_VALID = win_valid;
  assign bus.BUSY      = busy;

endmodule

// File: tb/tb_answer_judge.sv
// Self-checking bench for answer_judge: vector table plus
// hand-written round sequences, verdicts checked through a queue.
module tb_answer_judge;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  answer_judge_if #(
    .PLAYERS(2), .DIGITS(3), .DIGIT_W(4)
  ) jif ();

  answer_judge #(
    .PLAYERS(2), .DIGITS(3), .DIGIT_W(4),
    .MAX_TRIES(2), .TIMEOUT_CYC(20)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (jif)
  );

  typedef struct {
    logic [11:0] key;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [1:0]  sub;
    logic [3:0]  res;
    logic        win;
    logic        wv;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [3:0] res;
    logic       win;
    logic       wv;
    logic       busy;
  } exp_t;

  vec_t tbl[9];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm,
                         input exp_t e);
    chk({nm, ".result"}, 32'(jif.RESULT), 32'(e.res));
    chk({nm, ".win_valid"}, 32'(jif.WIN_VALID), 32'(e.wv));
    chk({nm, ".busy"}, 32'(jif.BUSY), 32'(e.busy));
    if (e.wv)
      chk({nm, ".winner"}, 32'(jif.WINNER), 32'(e.win));
  endtask

  task automatic pop_chk(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      bad++;
      total++;
      $display("FAIL %s: got empty queue want entry", nm);
    end else begin
      e = sbq.pop_front();
      chk_out(nm, e);
    end
  endtask

  task automatic do_reset(input string nm);
    RST_N        = 1'b0;
    jif.Q_VALID  = 1'b1;
    jif.QUESTION = {12'h000, 12'h777};
    jif.SUBMIT   = 2'b11;
    jif.ANSWER   = {12'h777, 12'h777};
    @(negedge CLK);
    chk_out(nm, '{4'b0000, 1'b0, 1'b0, 1'b0});
    chk({nm, ".winner"}, 32'(jif.WINNER), 32'd0);
    RST_N       = 1'b1;
    jif.Q_VALID = 1'b0;
    jif.SUBMIT  = 2'b00;
  endtask

  task automatic load(input logic [11:0] k);
    jif.Q_VALID  = 1'b1;
    jif.QUESTION = {12'hEEE, k};
    @(negedge CLK);
    jif.Q_VALID  = 1'b0;
    jif.QUESTION = '0;
  endtask

  task automatic do_sub(input logic [1:0] m,
                        input logic [11:0] a0,
                        input logic [11:0] a1,
                        input exp_t e,
                        input string nm);
    jif.ANSWER = {a1, a0};
    jif.SUBMIT = m;
    sbq.push_back(e);
    @(negedge CLK);
    jif.SUBMIT = 2'b00;
    @(negedge CLK);
    pop_chk(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{12'h321, 12'h000, 12'h321, 2'b10, 4'b0100, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{12'h321, 12'h321, 12'h321, 2'b11, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{12'h321, 12'h123, 12'h000, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{12'hABC, 12'hABC, 12'hABD, 2'b11, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{12'h5A5, 12'h000, 12'h5A5, 2'b11, 4'b0100, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{12'hFFF, 12'hFFF, 12'hFFF, 2'b10, 4'b0100, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{12'h001, 12'h101, 12'h000, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{12'h321, 12'h321, 12'h321, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{12'h321, 12'h321, 12'h320, 2'b10, 4'b1100, 1'b0, 1'b0, 1'b1};

    RST_N        = 1'b0;
    jif.Q_VALID  = 1'b0;
    jif.QUESTION = '0;
    jif.ANSWER   = '0;
    jif.SUBMIT   = '0;
    @(negedge CLK);

    for (int i = 0; i < 9; i++) begin
      do_reset($sformatf("v%0d.rst", i));
      load(tbl[i].key);
      chk($sformatf("v%0d.arm", i), 32'(jif.BUSY), 32'd1);
      jif.ANSWER = {tbl[i].a1, tbl[i].a0};
      jif.SUBMIT = tbl[i].sub;
      sbq.push_back('{tbl[i].res, tbl[i].win,
                      tbl[i].wv, tbl[i].busy});
      @(negedge CLK);
      jif.SUBMIT = 2'b00;
      chk($sformatf("v%0d.lat", i), 32'(jif.RESULT), 32'd0);
      @(negedge CLK);
      pop_chk($sformatf("v%0d", i));
    end

    // Try exhaustion, discarded submission, all players out.
    do_reset("ex.rst");
    load(12'h321);
    do_sub(2'b01, 12'h123, 12'h0, '{4'b0011, 1'b0, 1'b0, 1'b1}, "ex.ng1");
    do_sub(2'b01, 12'h123, 12'h0, '{4'b0011, 1'b0, 1'b0, 1'b1}, "ex.ng2");
    do_sub(2'b01, 12'h321, 12'h0, '{4'b0011, 1'b0, 1'b0, 1'b1}, "ex.drop");
    do_sub(2'b10, 12'h0, 12'h999, '{4'b1111, 1'b0, 1'b0, 1'b1}, "ex.p1ng");
    do_sub(2'b10, 12'h0, 12'h999, '{4'b1111, 1'b0, 1'b0, 1'b0}, "ex.out");

    // Timeout, late submission, DONE hold, re-arm, ARMED reload ignored.
    do_reset("to.rst");
    load(12'h321);
    repeat (19) @(negedge CLK);
    chk_out("to.pre", '{4'b0000, 1'b0, 1'b0, 1'b1});
    jif.ANSWER = {12'h321, 12'h000};
    jif.SUBMIT = 2'b10;
    @(negedge CLK);
    jif.SUBMIT = 2'b00;
    chk_out("to.hit", '{4'b1010, 1'b0, 1'b0, 1'b0});
    @(negedge CLK);
    chk_out("to.late", '{4'b1010, 1'b0, 1'b0, 1'b0});
    jif.Q_VALID  = 1'b1;
    jif.QUESTION = {12'h123, 12'h000};
    @(negedge CLK);
    jif.Q_VALID  = 1'b0;
    chk_out("to.zkey", '{4'b1010, 1'b0, 1'b0, 1'b0});
    load(12'h456);
    chk_out("to.rearm", '{4'b0000, 1'b0, 1'b0, 1'b1});
    load(12'h789);
    do_sub(2'b01, 12'h456, 12'h0, '{4'b0001, 1'b0, 1'b1, 1'b0}, "to.reload");

    // Correct verdict landing on the timeout cycle.
    do_reset("tc.rst");
    load(12'h321);
    repeat (18) @(negedge CLK);
    do_sub(2'b10, 12'h0, 12'h321, '{4'b0100, 1'b1, 1'b1, 1'b0}, "tc.win");
    repeat (2) @(negedge CLK);
    chk_out("tc.hold", '{4'b0100, 1'b1, 1'b1, 1'b0});

    // Zero key in IDLE, then reset mid-round.
    do_reset("rm.rst");
    jif.Q_VALID  = 1'b1;
    jif.QUESTION = {12'hFFF, 12'h000};
    @(negedge CLK);
    jif.Q_VALID  = 1'b0;
    chk("rm.zkey.busy", 32'(jif.BUSY), 32'd0);
    load(12'h321);
    do_sub(2'b01, 12'h123, 12'h0, '{4'b0011, 1'b0, 1'b0, 1'b1}, "rm.ng");
    do_reset("rm.mid");
    repeat (2) @(negedge CLK);
    chk_out("rm.after", '{4'b0000, 1'b0, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/answer_judge.md
ANSWER_JUDGE -- requirements
Module: answer_judge

Interface
REQ-001 The block SHALL have parameter PLAYERS, default 2, meaning number of competing players (1..8).
REQ-002 The block SHALL have parameter DIGITS, default 3, meaning answer digits per player.
REQ-003 The block SHALL have parameter DIGIT_W, default 4, meaning bits per digit.
REQ-004 The block SHALL have parameter MAX_TRIES, default 3, meaning wrong submissions allowed per player per round (1..15).
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 1000, meaning round length in CLK cycles (>=2).
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock.
REQ-007 The block SHALL have port RST_N, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port Q_VALID, input, 1 bit: one-cycle question-load strobe.
REQ-009 The block SHALL have port QUESTION, input, 2*DIGITS*DIGIT_W bits: low DIGITS*DIGIT_W bits are the key, digit 0 in the LSBs; upper half is ignored.
REQ-010 The block SHALL have port ANSWER, input, PLAYERS*DIGITS*DIGIT_W bits: player p's answer occupies slice p, same digit order as the key.
REQ-011 The block SHALL have port SUBMIT, input, PLAYERS bits: per-player one-cycle submit strobe.
REQ-012 The block SHALL have port RESULT, output, 2*PLAYERS bits: per-player code 00 pending, 01 correct, 11 wrong, 10 timed out.
REQ-013 The block SHALL have port WINNER, output, max(1,clog2(PLAYERS)) bits: index of the winning player.
REQ-014 The block SHALL have port WIN_VALID, output, 1 bit: WINNER is meaningful.
REQ-015 The block SHALL have port BUSY, output, 1 bit: a round is in progress.

Function
REQ-016 The block SHALL implement states IDLE, ARMED and DONE, with BUSY=1 only in ARMED.
REQ-017 In IDLE or DONE, Q_VALID=1 with a nonzero key SHALL latch the key, set all RESULT to 00, WIN_VALID to 0, every try counter to MAX_TRIES and the timer to 0, and enter ARMED on the next edge.
REQ-018 Q_VALID with an all-zero key SHALL be ignored in every state, so all outputs hold.
REQ-019 Q_VALID while in ARMED SHALL be ignored.
REQ-020 In ARMED, SUBMIT[p] and ANSWER slice p SHALL be registered at edge k, and the verdict SHALL appear on RESULT[p] after edge k+1 (2-cycle latency).
REQ-021 A submission from a player whose try counter is 0 SHALL be discarded.
REQ-022 A matching submission SHALL set RESULT[p]=01, WINNER=p and WIN_VALID=1, and enter DONE.
REQ-023 When several matching verdicts occur in one cycle, the lowest index SHALL win, and the other players' verdicts from that cycle SHALL be discarded with their RESULT unchanged.
REQ-024 A mismatching submission SHALL set RESULT[p]=11 and decrement that player's try counter, saturating at 0.
REQ-025 If every try counter reaches 0 with no winner, the block SHALL enter DONE with WIN_VALID=0 and RESULT held.
REQ-026 The timer SHALL increment every ARMED cycle; at TIMEOUT_CYC-1, every RESULT that is not 01 SHALL become 10 and the block SHALL enter DONE.
REQ-027 A correct verdict in the same cycle as the timeout SHALL take priority over the timeout, and no RESULT SHALL be set to 10.
REQ-028 Submissions still in the input register when the block leaves ARMED SHALL be discarded.
REQ-029 DONE SHALL hold all outputs until the next valid Q_VALID.

Reset
REQ-030 When RST_N=0 at a CLK edge, the block SHALL go to state IDLE with RESULT=0, WINNER=0, WIN_VALID=0, BUSY=0, timer=0, try counters=0, key=0 and the input register cleared.
REQ-031 Reset SHALL take priority over Q_VALID and SUBMIT.
REQ-032 A reset mid-round SHALL abandon the round with no verdict emitted.

Structure
REQ-033 Package judge_pkg SHALL hold the state enum and the RESULT code constants (RES_PEND, RES_OK, RES_NG, RES_TO).
REQ-034 A sub-module answer_cmp SHALL perform one player's DIGITS*DIGIT_W equality compare and SHALL be instantiated PLAYERS times.
REQ-035 Try counters SHALL be clog2(MAX_TRIES+1) bits wide, and the timer SHALL be clog2(TIMEOUT_CYC) bits wide.

Verification
All scenarios use PLAYERS=2, DIGITS=3, DIGIT_W=4, MAX_TRIES=2, TIMEOUT_CYC=20.
REQ-036 The bench SHALL cover: key 0x321; P1 submits 0x321 at edge k -> RESULT=01_00 after edge k+1, WINNER=1, WIN_VALID=1, BUSY=0.
REQ-037 The bench SHALL cover: key 0x321; P0 submits 0x123 twice, then 0x321 -> RESULT[0]=11 twice, the third submission is discarded, and RESULT[0] stays 11.
REQ-038 The bench SHALL cover: P0 and P1 both submit 0x321 in the same cycle -> WINNER=0, RESULT=00_01.
REQ-039 The bench SHALL cover: no submissions -> 20 cycles after ARMED, RESULT=10_10, WIN_VALID=0.
REQ-040 The bench SHALL cover: correct submit whose verdict lands at timer=19 -> RESULT[p]=01, no 10 codes.
REQ-041 The bench SHALL cover: Q_VALID with key 0x000 in IDLE leaves BUSY=0, and RST_N=0 mid-round returns all outputs to 0 on the next edge.
